// File: rtl/idct_pkg.sv
// Shared types and HEVC integer basis lookup for the N-point (i)DCT engine.
package idct_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StMac   = 2'd1,
    StRound = 2'd2,
    StOut   = 2'd3
  } state_e;

  // |HEVC 32-pt basis| indexed by the cosine angle m in units of pi/64, m = 0..32.
  // Index 0 is the DC value used by row 0.
  localparam logic [7:0] COS_MAG [33] = '{
    8'd64, 8'd90, 8'd90, 8'd90, 8'd89, 8'd88, 8'd87, 8'd85, 8'd83, 8'd82, 8'd80,
    8'd78, 8'd75, 8'd73, 8'd70, 8'd67, 8'd64, 8'd61, 8'd57, 8'd54, 8'd50, 8'd46,
    8'd43, 8'd38, 8'd36, 8'd31, 8'd25, 8'd22, 8'd18, 8'd13, 8'd9,  8'd4,  8'd0
  };

  // C(k,n) of the N-point transform: row k*(32/N) of the 32-pt matrix, column n.
  // The angle (2n+1)*row is folded onto [0,32] with the matching cosine sign.
  function automatic logic signed [7:0] coef(input int unsigned n_size, input int unsigned k,
                                             input int unsigned n);
    int unsigned th;
    logic [5:0]  idx;
    th = ((2 * n + 1) * k * (32 / n_size)) % 128;
    if (th > 64) th = 128 - th;
    if (th <= 32) begin
      idx = 6'(th);
      return $signed(COS_MAG[idx]);
    end
    idx = 6'(64 - th);
    return -$signed(COS_MAG[idx]);
  endfunction

endpackage

// File: rtl/idct_round_sat.sv
// Rounding arithmetic right-shift followed by saturation to OUT_W signed bits.
module idct_round_sat #(
  parameter int unsigned ACC_W   = 43,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic signed [ACC_W-1:0]   i_acc,
  input  logic        [SHIFT_W-1:0] i_shift,
  output logic signed [OUT_W-1:0]   o_res
);

  // One guard bit over whichever is wider: the accumulator or the largest rounding bias.
  localparam int unsigned EXT_W = ((ACC_W > (1 << SHIFT_W)) ? ACC_W : (1 << SHIFT_W)) + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic signed [EXT_W-1:0] w_bias;
  logic signed [EXT_W-1:0] w_sum;
  logic signed [EXT_W-1:0] w_shr;

  // Add half an LSB of the result, shift arithmetically, then clamp.
  always_comb begin
    w_bias = '0;
    if (i_shift != '0) w_bias = EXT_W'(1) << (i_shift - 1'b1);
    w_sum = EXT_W'(i_acc) + w_bias;
    w_shr = w_sum >>> i_shift;
    if (w_shr > MAX_V) begin
      o_res = MAX_V[OUT_W-1:0];
    end else if (w_shr < MIN_V) begin
      o_res = MIN_V[OUT_W-1:0];
    end else begin
      o_res = w_shr[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/idct_nx_stream.sv
// N-point 1-D integer DCT/IDCT engine: one input lane per MAC cycle, all outputs in parallel,
// followed by a round/saturate stage and a valid/ready output register.
module idct_nx_stream
  import idct_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned IN_W    = 32,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_s_valid,
  output logic                 o_s_ready,
  input  logic                 i_inverse,
  input  logic [SHIFT_W-1:0]   i_shift_amount,
  input  logic [N*IN_W-1:0]    i_data_in,
  output logic                 o_m_valid,
  input  logic                 i_m_ready,
  output logic [N*OUT_W-1:0]   o_data_out
);

  localparam int unsigned ACC_W = IN_W + 8 + $clog2(N);
  localparam int unsigned K_W   = $clog2(N);

  if (!((N == 4) || (N == 8) || (N == 16) || (N == 32))) begin : g_bad_n
    $error("idct_nx_stream: N must be 4, 8, 16 or 32");
  end

  state_e                  r_state;
  logic [K_W-1:0]          r_k;
  logic                    r_inv;
  logic [SHIFT_W-1:0]      r_sh;
  logic                    r_s_ready;
  logic                    r_m_valid;
  logic [N*OUT_W-1:0]      r_data_out;
  logic signed [IN_W-1:0]  r_in  [N];
  logic signed [ACC_W-1:0] r_acc [N];

  logic                    w_accept;
  logic signed [IN_W-1:0]  w_x;
  logic signed [7:0]       w_cf   [N];
  logic signed [IN_W+7:0]  w_prod [N];
  logic [N*OUT_W-1:0]      w_rnd;

  assign w_accept   = i_s_valid && r_s_ready;
  assign w_x        = r_in[r_k];
  assign o_s_ready  = r_s_ready;
  assign o_m_valid  = r_m_valid;
  assign o_data_out = r_data_out;

  for (genvar j = 0; j < N; j++) begin : g_lane
    // Per-lane constant coefficient columns, selected by the running input index.
    logic signed [7:0] w_cf_inv [N];
    logic signed [7:0] w_cf_fwd [N];
    for (genvar k = 0; k < N; k++) begin : g_cf
      assign w_cf_inv[k] = coef(N, k, j);
      assign w_cf_fwd[k] = coef(N, j, k);
    end
    assign w_cf[j]   = r_inv ? w_cf_inv[r_k] : w_cf_fwd[r_k];
    assign w_prod[j] = (IN_W + 8)'(w_x) * (IN_W + 8)'(w_cf[j]);

    idct_round_sat #(
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W),
      .SHIFT_W(SHIFT_W)
    ) u_round_sat (
      .i_acc  (r_acc[j]),
      .i_shift(r_sh),
      .o_res  (w_rnd[j*OUT_W +: OUT_W])
    );
  end

  // Control FSM with registered handshake outputs and output data register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_k        <= '0;
      r_inv      <= 1'b0;
      r_sh       <= '0;
      r_s_ready  <= 1'b1;
      r_m_valid  <= 1'b0;
      r_data_out <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state   <= StMac;
            r_k       <= '0;
            r_inv     <= i_inverse;
            r_sh      <= i_shift_amount;
            r_s_ready <= 1'b0;
          end
        end
        StMac: begin
          r_k <= r_k + 1'b1;
          if (r_k == K_W'(N - 1)) r_state <= StRound;
        end
        StRound: begin
          r_data_out <= w_rnd;
          r_m_valid  <= 1'b1;
          r_state    <= StOut;
        end
        StOut: begin
          if (i_m_ready) begin
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Input latch on accept; accumulators cleared on accept and updated once per MAC cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_in[i]  <= '0;
        r_acc[i] <= '0;
      end
    end else if (r_state == StIdle && w_accept) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_in[i]  <= i_data_in[i*IN_W +: IN_W];
        r_acc[i] <= '0;
      end
    end else if (r_state == StMac) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_acc[i] <= r_acc[i] + ACC_W'(w_prod[i]);
      end
    end
  end

endmodule

// File: tb/tb_idct_nx_stream.sv
// Scoreboard bench: three engines (N=8/OUT_W=16, N=4, N=32) checked against a
// plain-arithmetic transform model; a monitor per engine pops expected vectors on handshake.
module tb_idct_nx_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  // DUT A: N=8, OUT_W=16
  logic         a_rst_n, a_s_valid, a_s_ready, a_inv, a_m_valid, a_m_ready;
  logic [4:0]   a_sh;
  logic [255:0] a_din;
  logic [127:0] a_dout;
  // DUT B: N=4, DUT C: N=32 (shared reset)
  logic          rst_n;
  logic          b_s_valid, b_s_ready, b_inv, b_m_valid, b_m_ready;
  logic [4:0]    b_sh;
  logic [127:0]  b_din, b_dout;
  logic          c_s_valid, c_s_ready, c_inv, c_m_valid, c_m_ready;
  logic [4:0]    c_sh;
  logic [1023:0] c_din, c_dout;

  idct_nx_stream #(.N(8), .IN_W(32), .OUT_W(16), .SHIFT_W(5)) u_dut_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_s_valid(a_s_valid), .o_s_ready(a_s_ready),
    .i_inverse(a_inv), .i_shift_amount(a_sh), .i_data_in(a_din), .o_m_valid(a_m_valid),
    .i_m_ready(a_m_ready), .o_data_out(a_dout));
  idct_nx_stream #(.N(4), .IN_W(32), .OUT_W(32), .SHIFT_W(5)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_s_valid(b_s_valid), .o_s_ready(b_s_ready),
    .i_inverse(b_inv), .i_shift_amount(b_sh), .i_data_in(b_din), .o_m_valid(b_m_valid),
    .i_m_ready(b_m_ready), .o_data_out(b_dout));
  idct_nx_stream #(.N(32), .IN_W(32), .OUT_W(32), .SHIFT_W(5)) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_s_valid(c_s_valid), .o_s_ready(c_s_ready),
    .i_inverse(c_inv), .i_shift_amount(c_sh), .i_data_in(c_din), .o_m_valid(c_m_valid),
    .i_m_ready(c_m_ready), .o_data_out(c_dout));

  logic [1023:0] q_a[$], q_b[$], q_c[$];
  bit b_done = 0, c_done = 0, rnd_ready = 0;
  int a_acc_cyc;

  // ---------------- reference model ----------------
  int mag_tbl [33] = '{64, 90, 90, 90, 89, 88, 87, 85, 83, 82, 80, 78, 75, 73, 70, 67, 64,
                       61, 57, 54, 50, 46, 43, 38, 36, 31, 25, 22, 18, 13, 9, 4, 0};

  // Magnitude from the folded angle, sign taken from the real cosine.
  function automatic int bcoef(input int n_size, input int k, input int n);
    int  kk, m;
    real v;
    kk = k * (32 / n_size);
    m  = ((2 * n + 1) * kk) % 64;
    if (m > 32) m = 64 - m;
    v = $cos(3.14159265358979 * real'((2 * n + 1) * kk) / 64.0);
    return (v < 0.0) ? -mag_tbl[m] : mag_tbl[m];
  endfunction

  function automatic logic [1023:0] ref_vec(input int n, input int outw, input bit inv,
                                            input int sh, input logic [1023:0] din);
    logic [1023:0] res, mask;
    longint acc, x, maxv, minv;
    res  = '0;
    mask = (1024'(1) << outw) - 1;
    maxv = (longint'(1) <<< (outw - 1)) - 1;
    minv = -(longint'(1) <<< (outw - 1));
    for (int j = 0; j < n; j++) begin
      acc = 0;
      for (int k = 0; k < n; k++) begin
        x   = longint'($signed(din[k*32 +: 32]));
        acc += x * longint'(inv ? bcoef(n, k, j) : bcoef(n, j, k));
      end
      if (sh != 0) acc = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
      if (acc > maxv) acc = maxv;
      if (acc < minv) acc = minv;
      res |= ({960'b0, acc} & mask) << (j * outw);
    end
    return res;
  endfunction

  function automatic logic [31:0] rnd_lane();
    case ($urandom_range(0, 2))
      0:       return 32'($urandom_range(0, 2000)) - 32'd1000;
      1:       return 32'($urandom_range(0, 2097152)) - 32'd1048576;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  function automatic logic signed [63:0] lane_of(input logic [1023:0] v, input int j,
                                                 input int outw);
    logic [1023:0]      t;
    logic signed [63:0] r;
    t = v >> (j * outw);
    r = t[63:0];
    r = (r <<< (64 - outw)) >>> (64 - outw);
    return r;
  endfunction

  task automatic chk_vec(input string name, input logic [1023:0] act, input logic [1023:0] exp,
                         input int n, input int outw);
    int bad = -1;
    checks++;
    for (int j = 0; j < n; j++)
      if (bad < 0 && lane_of(act, j, outw) !== lane_of(exp, j, outw)) bad = j;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s lane %0d: got %0d expected %0d", name, bad, lane_of(act, bad, outw),
               lane_of(exp, bad, outw));
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (a_rst_n && a_m_valid && a_m_ready) begin
      if (q_a.size() == 0) chk("a_unexpected_output", 64'd1, 64'd0);
      else chk_vec("a_data", {896'b0, a_dout}, q_a.pop_front(), 8, 16);
    end
    if (rst_n && b_m_valid && b_m_ready) begin
      if (q_b.size() == 0) chk("b_unexpected_output", 64'd1, 64'd0);
      else chk_vec("b_data", {896'b0, b_dout}, q_b.pop_front(), 4, 32);
    end
    if (rst_n && c_m_valid && c_m_ready) begin
      if (q_c.size() == 0) chk("c_unexpected_output", 64'd1, 64'd0);
      else chk_vec("c_data", c_dout, q_c.pop_front(), 32, 32);
    end
  end

  // Random output backpressure for DUT A.
  always @(posedge clk) begin
    #1;
    if (rnd_ready) a_m_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- DUT A driver ----------------
  task automatic send_a(input bit inv, input int sh, input logic [255:0] din,
                        input logic [1023:0] exp);
    bit ok = 0;
    a_inv = inv; a_sh = sh[4:0]; a_din = din; a_s_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (a_s_ready) begin
        q_a.push_back(exp);
        @(posedge clk);
        a_acc_cyc = cyc;
        #1;
        ok = 1;
        break;
      end
    end
    // Scramble inputs after accept; the vector in flight must not see them.
    a_s_valid = 1'b0;
    a_din = {8{$urandom}};
    a_inv = ~inv;
    a_sh  = 5'($urandom);
    chk("a_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain_a();
    for (int i = 0; i < 400 && q_a.size() != 0; i++) @(posedge clk);
    #1;
    chk("a_drain_pending", 64'(q_a.size()), 64'd0);
  endtask

  function automatic logic [1023:0] fill16(input int v0, input int rest);
    logic [1023:0] e = '0;
    for (int j = 0; j < 8; j++) e[j*16 +: 16] = 16'((j == 0) ? v0 : rest);
    return e;
  endfunction

  initial begin : main
    logic [255:0]  d, d2;
    logic [1023:0] e, e2;
    int lat, t1;
    bit seen;
    a_rst_n = 1'b0; rst_n = 1'b0; a_s_valid = 1'b0; a_inv = 1'b0; a_sh = '0; a_din = '0;
    a_m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("a_reset_s_ready", 64'(a_s_ready), 64'd1);
    chk("a_reset_m_valid", 64'(a_m_valid), 64'd0);
    chk("a_reset_data_out", 64'(a_dout == '0), 64'd1);
    a_rst_n = 1'b1; rst_n = 1'b1;
    @(posedge clk); #1;

    // IDCT of a DC-only vector; also measure output latency in edges after accept.
    d = '0; d[31:0] = 32'd100;
    send_a(1'b1, 7, d, fill16(50, 50));
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1; lat++;
      if (a_m_valid) break;
    end
    // m_valid is seen in cycle N+2 counting the accept cycle as cycle 0.
    chk("a_latency_edges", 64'(lat), 64'd9);
    drain_a();

    // Forward DCT of a flat vector: only DC survives.
    d = {8{32'd100}};
    send_a(1'b0, 11, d, fill16(25, 0));
    drain_a();

    // Saturation at both rails with OUT_W=16.
    d = '0; d[31:0] = 32'h7FFF_FFFF;
    send_a(1'b1, 0, d, fill16(32767, 32767));
    d = '0; d[31:0] = 32'h8000_0000;
    send_a(1'b1, 0, d, fill16(-32768, -32768));
    drain_a();

    // Back-to-back throughput with m_ready held high.
    for (int l = 0; l < 8; l++) d[l*32 +: 32] = rnd_lane();
    send_a(1'b1, 9, d, ref_vec(8, 16, 1'b1, 9, {768'b0, d}));
    t1 = a_acc_cyc;
    for (int l = 0; l < 8; l++) d[l*32 +: 32] = rnd_lane();
    send_a(1'b0, 12, d, ref_vec(8, 16, 1'b0, 12, {768'b0, d}));
    chk("a_throughput_edges", 64'(a_acc_cyc - t1), 64'd11);
    drain_a();

    // Backpressure: output held, second vector offered but refused until release.
    a_m_ready = 1'b0;
    for (int l = 0; l < 8; l++) d[l*32 +: 32] = rnd_lane();
    e = ref_vec(8, 16, 1'b1, 6, {768'b0, d});
    send_a(1'b1, 6, d, e);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (a_m_valid) begin seen = 1; break; end
    end
    chk("a_bp_m_valid_rise", 64'(seen), 64'd1);
    for (int l = 0; l < 8; l++) d2[l*32 +: 32] = rnd_lane();
    e2 = ref_vec(8, 16, 1'b0, 4, {768'b0, d2});
    a_inv = 1'b0; a_sh = 5'd4; a_din = d2; a_s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("a_bp_s_ready_low", 64'(a_s_ready), 64'd0);
      chk("a_bp_m_valid_held", 64'(a_m_valid), 64'd1);
      chk_vec("a_bp_data_stable", {896'b0, a_dout}, e, 8, 16);
      @(posedge clk); #1;
    end
    a_m_ready = 1'b1;
    @(posedge clk); #1;
    chk("a_bp_release_m_valid", 64'(a_m_valid), 64'd0);
    chk("a_bp_release_s_ready", 64'(a_s_ready), 64'd1);
    send_a(1'b0, 4, d2, e2);
    drain_a();

    // Reset while the MAC counter is at 3: vector discarded, outputs back to reset values.
    for (int l = 0; l < 8; l++) d[l*32 +: 32] = rnd_lane();
    send_a(1'b1, 7, d, ref_vec(8, 16, 1'b1, 7, {768'b0, d}));
    repeat (3) @(posedge clk);
    #1;
    a_rst_n = 1'b0;
    #1;
    chk("a_midreset_m_valid", 64'(a_m_valid), 64'd0);
    chk("a_midreset_s_ready", 64'(a_s_ready), 64'd1);
    chk("a_midreset_data_out", 64'(a_dout == '0), 64'd1);
    q_a.delete();
    @(posedge clk); #1;
    a_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("a_postreset_s_ready", 64'(a_s_ready), 64'd1);
    chk("a_postreset_m_valid", 64'(a_m_valid), 64'd0);
    d = '0; d[63:32] = 32'd128;
    send_a(1'b1, 7, d, ref_vec(8, 16, 1'b1, 7, {768'b0, d}));
    drain_a();

    // Randomised vectors with random output backpressure.
    rnd_ready = 1;
    for (int t = 0; t < 40; t++) begin
      bit inv;
      int sh;
      inv = 1'($urandom_range(0, 1));
      sh  = $urandom_range(0, 20);
      for (int l = 0; l < 8; l++) d[l*32 +: 32] = rnd_lane();
      send_a(inv, sh, d, ref_vec(8, 16, inv, sh, {768'b0, d}));
    end
    rnd_ready = 0;
    @(posedge clk); #1;
    a_m_ready = 1'b1;
    drain_a();

    for (int i = 0; i < 5000 && !(b_done && c_done); i++) @(posedge clk);
    chk("bc_done", 64'(b_done && c_done), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- DUT B (N=4) driver ----------------
  initial begin : drv_b
    logic [127:0]  d;
    logic [1023:0] e;
    bit ok, inv;
    int sh;
    b_s_valid = 1'b0; b_din = '0; b_inv = 1'b0; b_sh = '0; b_m_ready = 1'b1;
    wait (rst_n);
    @(posedge clk); #1;
    for (int t = 0; t < 5; t++) begin
      if (t == 0) begin
        inv = 1'b1; sh = 7; d = '0; d[63:32] = 32'd128;
        e = '0;
        e[31:0] = 32'(83); e[63:32] = 32'(36); e[95:64] = 32'(-36); e[127:96] = 32'(-83);
      end else begin
        inv = 1'($urandom_range(0, 1));
        sh  = $urandom_range(0, 20);
        for (int l = 0; l < 4; l++) d[l*32 +: 32] = rnd_lane();
        e = ref_vec(4, 32, inv, sh, {896'b0, d});
      end
      b_inv = inv; b_sh = sh[4:0]; b_din = d; b_s_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (b_s_ready) begin q_b.push_back(e); @(posedge clk); #1; ok = 1; break; end
      end
      b_s_valid = 1'b0;
      chk("b_accept", 64'(ok), 64'd1);
    end
    for (int i = 0; i < 200 && q_b.size() != 0; i++) @(posedge clk);
    #1;
    chk("b_drain_pending", 64'(q_b.size()), 64'd0);
    b_done = 1;
  end

  // ---------------- DUT C (N=32) driver ----------------
  initial begin : drv_c
    logic [1023:0] d, e;
    int m16 [16] = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};
    bit ok, inv;
    int sh;
    c_s_valid = 1'b0; c_din = '0; c_inv = 1'b0; c_sh = '0; c_m_ready = 1'b1;
    wait (rst_n);
    @(posedge clk); #1;
    for (int t = 0; t < 4; t++) begin
      if (t == 0) begin
        // Basis row 1 scaled by 128 then rounded back: lanes equal C(1,n).
        inv = 1'b1; sh = 7; d = '0; d[63:32] = 32'd128;
        e = '0;
        for (int n = 0; n < 32; n++) e[n*32 +: 32] = 32'((n < 16) ? m16[n] : -m16[31 - n]);
      end else begin
        inv = 1'($urandom_range(0, 1));
        sh  = $urandom_range(0, 20);
        for (int l = 0; l < 32; l++) d[l*32 +: 32] = rnd_lane();
        e = ref_vec(32, 32, inv, sh, d);
      end
      c_inv = inv; c_sh = sh[4:0]; c_din = d; c_s_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (c_s_ready) begin q_c.push_back(e); @(posedge clk); #1; ok = 1; break; end
      end
      c_s_valid = 1'b0;
      chk("c_accept", 64'(ok), 64'd1);
    end
    for (int i = 0; i < 300 && q_c.size() != 0; i++) @(posedge clk);
    #1;
    chk("c_drain_pending", 64'(q_c.size()), 64'd0);
    c_done = 1;
  end

endmodule
